e203_sram_icb_ctrl: RTL



---
 rtl/e203_sram_icb_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/e203_sram_icb_ctrl.sv
// ICB-to-SRAM initiator: single-beat ICB commands become TCM SRAM macro accesses, in-order responses.
// Latency: SRAM strobes in the handshake cycle, response one cycle later when the response buffer is empty.
// Backpressure: a 2-entry response buffer absorbs rsp_ready=0; cmd_ready drops once two responses are owed.
// Ports: i_icb_cmd_* (command in), i_icb_rsp_* (response out), ram_* (SRAM macro port with
//        1-cycle read latency on ram_dout), ram_ls/ram_ds/ram_sd (power pins), clk/rst_n.
module e203_sram_icb_ctrl #(
    parameter int AW          = 16,
    parameter int IDLE_LS_CYC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic [31:0]   i_icb_cmd_addr,
    input  logic          i_icb_cmd_read,
    input  logic [31:0]   i_icb_cmd_wdata,
    input  logic [3:0]    i_icb_cmd_wmask,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic [31:0]   i_icb_rsp_rdata,
    output logic          i_icb_rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_wem,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    localparam int ICW = $clog2(IDLE_LS_CYC + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef enum logic {ST_ACTIVE, ST_LS} state_t;

    logic           s1_vld_q, s1_read_q, s1_err_q;
    logic [1:0]     fifo_cnt_q, fifo_cnt_d;
    rsp_t           fifo_q [2];
    logic           wptr_q, rptr_q;
    state_t         state_q;
    logic [ICW-1:0] idle_cnt_q;

    logic       in_range, cmd_hs, fifo_empty, push, pop, idle_cyc;
    logic [1:0] owed;
    rsp_t       s1_rsp, rsp;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^i_icb_cmd_addr[1:0];

    // Credits use only registered state, so a pop frees its slot one cycle later.
    assign owed            = {1'b0, s1_vld_q} + fifo_cnt_q;
    assign i_icb_cmd_ready = (state_q == ST_ACTIVE) && (owed < 2'd2);
    assign cmd_hs          = i_icb_cmd_valid & i_icb_cmd_ready;
    assign in_range        = (i_icb_cmd_addr[31:AW+2] == '0);

    // Out-of-range commands never touch the macro but still flow through s1.
    assign ram_cs   = cmd_hs & in_range;
    assign ram_we   = ram_cs & ~i_icb_cmd_read;
    assign ram_wem  = ram_we ? i_icb_cmd_wmask : 4'h0;
    assign ram_addr = i_icb_cmd_addr[AW+1:2];
    assign ram_din  = i_icb_cmd_wdata;
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    // ram_dout is only meaningful in the cycle after a read strobe, i.e. while s1 holds that read.
    assign s1_rsp.err   = s1_err_q;
    assign s1_rsp.rdata = (s1_read_q & ~s1_err_q) ? ram_dout : 32'h0;

    assign fifo_empty = (fifo_cnt_q == 2'd0);
    // s1 bypasses the buffer only when nothing older is queued and the consumer can take it now.
    assign push       = s1_vld_q & (~fifo_empty | ~i_icb_rsp_ready);
    assign pop        = ~fifo_empty & i_icb_rsp_ready;

    assign rsp             = fifo_empty ? s1_rsp : fifo_q[rptr_q];
    assign i_icb_rsp_valid = fifo_empty ? s1_vld_q : 1'b1;
    assign i_icb_rsp_rdata = rsp.rdata;
    assign i_icb_rsp_err   = rsp.err;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_read_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            s1_vld_q   <= cmd_hs;
            s1_read_q  <= cmd_hs & i_icb_cmd_read;
            s1_err_q   <= cmd_hs & ~in_range;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= s1_rsp;
                wptr_q         <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    assign idle_cyc = ~i_icb_cmd_valid & ~s1_vld_q & fifo_empty;

    // Light-sleep FSM; ram_ls is the registered state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (idle_cyc) begin
                        if (idle_cnt_q == ICW'(IDLE_LS_CYC - 1)) begin
                            state_q    <= ST_LS;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_q <= '0;
                    end
                end
                ST_LS: begin
                    // One wake cycle: the command is accepted no earlier than the following cycle.
                    if (i_icb_cmd_valid) begin
                        state_q    <= ST_ACTIVE;
                        idle_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_ACTIVE;
                    idle_cnt_q <= '0;
                end
            endcase
        end
    end

    assign ram_ls = (state_q == ST_LS);

endmodule
